// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the core memory stage and the data RAM.
// Translates funct3-typed requests into RAM size/address/data commands, absorbs the
// RAM's one-cycle read latency, and splits word-crossing accesses into read-modify-write
// sequences over words N and N+1.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- word-crossing requests complete at once
// with fault=1 and no RAM access instead of being split.
module lsu_align #(
  parameter int unsigned N = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        ram_we,
  output logic [1:0]  ram_mem_ctrl,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out
);

  // RAM size codes
  localparam logic [1:0] STORE_B  = 2'b00;
  localparam logic [1:0] STORE_HW = 2'b01;
  localparam logic [1:0] STORE_W  = 2'b10;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_LO = 3'd1;
  localparam logic [2:0] S_RD_HI = 3'd2;
  localparam logic [2:0] S_WR_HI = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Word N+1 is always formed on 30 bits; the RAM keeps only addr[N+1:2], so wrap is its job.
  if (N > 30) begin : g_ram_wider_than_addr
  end

  function automatic logic [1:0] size_code(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_code = STORE_B;
      3'b001, 3'b101: size_code = STORE_HW;
      default:        size_code = STORE_W;
    endcase
  endfunction

  function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
    case (size_code(f3))
      STORE_B:  is_split = 1'b0;
      STORE_HW: is_split = (off == 2'd3);
      default:  is_split = (off != 2'd0);
    endcase
  endfunction

  // Shift the {hi,lo} pair down to the addressed byte, then size and extend.
  function automatic logic [31:0] extract(input logic [63:0] dw, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [31:0] sh;
    sh = 32'(dw >> {off, 3'b000});
    case (size_code(f3))
      STORE_B:  extract = f3[2] ? {24'd0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
      STORE_HW: extract = f3[2] ? {16'd0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
      default:  extract = sh;
    endcase
  endfunction

  logic [2:0]  state_q, state_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ram_we_raw;

  logic [29:0] word_n1;
  logic [31:0] byte_mask;
  logic [63:0] wmask;
  logic [63:0] wshift;
  logic [63:0] merged;

  // Store data merged into the {hi,lo} pair read back from words N and N+1
  assign word_n1   = addr_q[31:2] + 30'd1;
  assign byte_mask = (size_code(f3_q) == STORE_HW) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  assign wmask     = {32'd0, byte_mask} << {addr_q[1:0], 3'b000};
  assign wshift    = {32'd0, wdata_q} << {addr_q[1:0], 3'b000};
  assign merged    = ({hi_q, lo_q} & ~wmask) | (wshift & wmask);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and RAM command decode
  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    rdata_d      = rdata_q;
    fault_d      = 1'b0;
    lo_d         = lo_q;
    hi_d         = hi_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    busy         = 1'b0;
    ram_we_raw   = 1'b0;
    ram_mem_ctrl = size_code(f3_q);
    ram_address  = addr_q;
    ram_data_in  = wdata_q;

    case (state_q)
      S_IDLE: begin
        ram_mem_ctrl = size_code(req_funct3);
        ram_address  = req_addr;
        ram_data_in  = req_wdata;
        if (req_valid) begin
          busy    = 1'b1;
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (is_split(req_funct3, req_addr[1:0])) begin
`ifdef LSU_MISALIGN_TRAP_EN
            state_d = S_DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
            rdata_d = '0;
`else
            state_d = S_RD_LO;
`endif
          end else if (req_we) begin
            ram_we_raw = 1'b1;
            state_d    = S_DONE;
            done_d     = 1'b1;
          end else begin
            state_d = S_RD_LO;
          end
        end
      end
      S_RD_LO: begin
        busy = 1'b1;
        lo_d = ram_data_out;
        if (is_split(f3_q, addr_q[1:0])) begin
          ram_mem_ctrl = STORE_W;
          ram_address  = {word_n1, 2'b00};
          state_d      = S_RD_HI;
        end else begin
          rdata_d = extract({32'd0, ram_data_out}, f3_q, addr_q[1:0]);
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RD_HI: begin
        busy         = 1'b1;
        ram_mem_ctrl = STORE_W;
        ram_address  = {word_n1, 2'b00};
        if (we_q) begin
          hi_d        = ram_data_out;
          ram_we_raw  = 1'b1;
          ram_address = {addr_q[31:2], 2'b00};
          ram_data_in = merged[31:0];
          state_d     = S_WR_HI;
        end else begin
          rdata_d = extract({ram_data_out, lo_q}, f3_q, addr_q[1:0]);
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WR_HI: begin
        busy         = 1'b1;
        ram_we_raw   = 1'b1;
        ram_mem_ctrl = STORE_W;
        ram_address  = {word_n1, 2'b00};
        ram_data_in  = merged[63:32];
        done_d       = 1'b1;
        state_d      = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A write must never escape while reset is asserted
  assign ram_we = ram_we_raw & ~rst;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: bench for lsu_align with a behavioural word RAM and a byte-level reference memory.
`timescale 1ns/1ps
module tb_lsu_align;
  localparam int unsigned N     = 8;
  localparam int unsigned WORDS = 1 << N;
  localparam int unsigned BYTES = WORDS * 4;
  localparam int unsigned BW    = N + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic        ram_we;
  logic [1:0]  ram_mem_ctrl;
  logic [31:0] ram_address;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram     [WORDS] = '{default: '0};
  logic [7:0]  ref_mem [BYTES] = '{default: '0};

  always #5 clk = ~clk;

  lsu_align #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .busy         (busy),
    .done         (done),
    .rdata        (rdata),
    .fault        (fault),
    .ram_we       (ram_we),
    .ram_mem_ctrl (ram_mem_ctrl),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  // Data RAM: lane placement by size code, registered read
  always @(posedge clk) begin
    if (ram_we) begin
      case (ram_mem_ctrl)
        2'b00:   ram[ram_address[N+1:2]][{ram_address[1:0], 3'b000} +: 8]  <= ram_data_in[7:0];
        2'b01:   ram[ram_address[N+1:2]][{ram_address[1:0], 3'b000} +: 16] <= ram_data_in[15:0];
        default: ram[ram_address[N+1:2]] <= ram_data_in;
      endcase
    end else begin
      ram_data_out <= ram[ram_address[N+1:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int sz(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Reference load: gather bytes in address order, wrapping over the RAM's byte space
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < sz(f3); i++) v[8*i +: 8] = ref_mem[BW'(a + 32'(i))];
    if (f3 == 3'b000 && v[7])  v[31:8]  = '1;
    if (f3 == 3'b001 && v[15]) v[31:16] = '1;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < sz(f3); i++) ref_mem[BW'(a + 32'(i))] = wd[8*i +: 8];
  endtask

  // Issue one request and hold it until done; optionally scramble req_* after acceptance.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit scr,
                         output int lat, output logic [31:0] rd, output logic flt,
                         output int wes, output int bsy);
    lat = -1; rd = '0; flt = 1'b0; wes = 0; bsy = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
    for (int c = 0; c < 16; c++) begin
      if (done) begin
        lat = c; rd = rdata; flt = fault;
        break;
      end
      if (ram_we) wes++;
      if (busy) bsy++;
      @(negedge clk);
      if (scr) begin
        req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
      #1;
    end
    if (lat < 0) $display("FAIL timeout: no done for addr %h", a);
    req_valid = 1'b0;
  endtask

  // Random op checked against the reference memory
  task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int k);
    int lat, wes, bsy, elat, ewes;
    logic [31:0] rd, erd;
    logic flt, efl, split;
    split = (int'(a[1:0]) + sz(f3)) > 4;
    efl = 1'b0; erd = '0; ewes = 0;
    if (we) begin
      elat = split ? 4 : 1; ewes = split ? 2 : 1;
    end else begin
      elat = split ? 3 : 2; erd = ref_load(f3, a);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if (split) begin
      elat = 1; ewes = 0; efl = 1'b1; erd = '0;
    end
`endif
    run_req(we, f3, a, wd, 1'b1, lat, rd, flt, wes, bsy);
    chk($sformatf("rnd%0d_lat", k),   32'(lat), 32'(elat));
    chk($sformatf("rnd%0d_we", k),    32'(wes), 32'(ewes));
    chk($sformatf("rnd%0d_busy", k),  32'(bsy), 32'(elat));
    chk($sformatf("rnd%0d_fault", k), 32'(flt), 32'(efl));
    if (!we || efl) chk($sformatf("rnd%0d_rdata", k), rd, erd);
    if (we && !efl) ref_store(f3, a, wd);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_wes;
  } vec_t;

  vec_t vt [$];

  initial begin
    int lat, wes, bsy;
    logic [31:0] rd;
    logic flt;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;

    // Reset with a store request pending: no write may reach the RAM
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    #1;
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    @(negedge clk); #1;
    chk("reset_done",  32'(done),  32'd0);
    chk("reset_rdata", rdata,      32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_ram_we2", 32'(ram_we), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);

`ifndef LSU_MISALIGN_TRAP_EN
    // {we, funct3, addr, wdata, expected rdata, latency, ram_we cycles}
    vt.push_back('{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        1, 1});
    vt.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 2, 0});
    vt.push_back('{1'b1, 3'b010, 32'h10, 32'h808182F3, 32'h0,        1, 1});
    vt.push_back('{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 2, 0});
    vt.push_back('{1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 2, 0});
    vt.push_back('{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF8081, 2, 0});
    vt.push_back('{1'b0, 3'b101, 32'h11, 32'h0,        32'h00008182, 2, 0});
    vt.push_back('{1'b1, 3'b010, 32'h10, 32'h44332211, 32'h0,        1, 1});
    vt.push_back('{1'b1, 3'b010, 32'h14, 32'h88776655, 32'h0,        1, 1});
    vt.push_back('{1'b0, 3'b010, 32'h12, 32'h0,        32'h66554433, 3, 0});
    vt.push_back('{1'b0, 3'b001, 32'h13, 32'h0,        32'h00005544, 3, 0});
    vt.push_back('{1'b1, 3'b010, 32'h11, 32'hAABBCCDD, 32'h0,        4, 2});
    vt.push_back('{1'b0, 3'b010, 32'h10, 32'h0,        32'hBBCCDD11, 2, 0});
    vt.push_back('{1'b0, 3'b010, 32'h14, 32'h0,        32'h887766AA, 2, 0});
    vt.push_back('{1'b1, 3'b000, 32'h15, 32'h00000012, 32'h0,        1, 1});
    vt.push_back('{1'b1, 3'b001, 32'h16, 32'h0000BEEF, 32'h0,        1, 1});
    vt.push_back('{1'b0, 3'b011, 32'h14, 32'h0,        32'hBEEF12AA, 2, 0});
    vt.push_back('{1'b1, 3'b001, 32'h13, 32'h0000CAFE, 32'h0,        4, 2});
    vt.push_back('{1'b0, 3'b101, 32'h13, 32'h0,        32'h0000CAFE, 3, 0});
    vt.push_back('{1'b0, 3'b000, 32'h14, 32'h0,        32'hFFFFFFCA, 2, 0});
    vt.push_back('{1'b1, 3'b010, 32'hFFFFFFFE, 32'h11223344, 32'h0,  4, 2});
    vt.push_back('{1'b0, 3'b110, 32'hFFFFFFFE, 32'h0,  32'h11223344, 3, 0});
    vt.push_back('{1'b0, 3'b010, 32'h3FC, 32'h0,       32'h33440000, 2, 0});
    vt.push_back('{1'b0, 3'b010, 32'h0,   32'h0,       32'h00001122, 2, 0});
    vt.push_back('{1'b0, 3'b000, 32'h1,   32'h0,       32'h00000011, 2, 0});

    for (int i = 0; i < vt.size(); i++) begin
      run_req(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, 1'b0, lat, rd, flt, wes, bsy);
      chk($sformatf("vec%0d_lat", i),   32'(lat), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_we", i),    32'(wes), 32'(vt[i].exp_wes));
      chk($sformatf("vec%0d_busy", i),  32'(bsy), 32'(vt[i].exp_lat));
      chk($sformatf("vec%0d_fault", i), 32'(flt), 32'd0);
      if (!vt[i].we) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      else ref_store(vt[i].f3, vt[i].addr, vt[i].wdata);
    end

    // Split store abandoned by reset while in RD_LO
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h11; req_wdata = 32'h55667788;
    #1;
    chk("rstmid_accept_busy", 32'(busy), 32'd1);
    @(negedge clk); #1;
    chk("rstmid_rdlo_busy", 32'(busy), 32'd1);
    chk("rstmid_rdlo_we",   32'(ram_we), 32'd0);
    rst = 1'b1; req_valid = 1'b0;
    #1;
    chk("rstmid_forced_we", 32'(ram_we), 32'd0);
    @(negedge clk); #1;
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_we",   32'(ram_we), 32'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rstmid_after_done", 32'(done), 32'd0);
    chk("rstmid_after_busy", 32'(busy), 32'd0);
    chk("rstmid_word4", ram[4], 32'hFECCDD11);
    chk("rstmid_word5", ram[5], 32'hBEEF12CA);
`else
    // Trapped split load, then a native load from the same word
    run_req(1'b1, 3'b010, 32'h10, 32'h44332211, 1'b0, lat, rd, flt, wes, bsy);
    chk("trap_sw_lat", 32'(lat), 32'd1);
    ref_store(3'b010, 32'h10, 32'h44332211);
    run_req(1'b0, 3'b010, 32'h12, 32'h0, 1'b0, lat, rd, flt, wes, bsy);
    chk("trap_lat",   32'(lat), 32'd1);
    chk("trap_fault", 32'(flt), 32'd1);
    chk("trap_rdata", rd,       32'd0);
    chk("trap_we",    32'(wes), 32'd0);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, lat, rd, flt, wes, bsy);
    chk("trap_next_lat",   32'(lat), 32'd2);
    chk("trap_next_fault", 32'(flt), 32'd0);
    chk("trap_next_rdata", rd,       32'h44332211);
`endif

    // Randomized requests, req_* scrambled after acceptance
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      if ($urandom_range(0, 1) == 1) a = $urandom;
      else a = 32'($urandom_range(0, BYTES - 1));
      model_op(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, k);
    end

    // Final RAM image against the reference memory
    for (int w = 0; w < WORDS; w++) begin
      chk($sformatf("mem_word%0d", w), ram[w],
          {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store unit between the core's memory stage and the data `ram`. It sits directly upstream of the RAM.
- Turns the core's funct3-typed requests into RAM commands: `mem_ctrl` size, byte address and store data.
- Absorbs the RAM's 1-cycle registered read latency.
- Splits word-crossing accesses into read-modify-write sequences, because the RAM cannot do them natively.
- Extracts and extends load data and stalls the core via `busy`.

Parameters:
- `N`, default 8, RAM word-address width. Used only to document wrap; word N+1 is computed on 30 bits and the RAM truncates it.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: core memory request; held with all `req_*` until `done`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; other codes treated as word.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `busy` out 1: core stall.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result, valid while `done`=1.
- `fault` out 1: misalignment fault, `done`-qualified; constant 0 unless LSU_MISALIGN_TRAP_EN.
- `ram_we` out 1: RAM write enable.
- `ram_mem_ctrl` out 2: `STORE_B`/`STORE_HW`/`STORE_W` codes from rv_defs.v.
- `ram_address` out 32: RAM byte address.
- `ram_data_in` out 32: RAM write data.
- `ram_data_out` in 32: RAM registered read data, valid 1 cycle after a read address with `ram_we`=0.

Behaviour:
- Reset: `rst`=1 at an edge → state IDLE, `done`=0, `rdata`=0, `fault`=0, latches cleared. `ram_we` forced 0 combinationally while `rst`=1.
- Reset mid split-store: the sequence is abandoned. Word N may already hold new data while word N+1 does not; this is accepted.
- Request classification, off = `req_addr[1:0]`:
  - Native: byte at any off; half at off 0–2; word at off 0.
  - Split: half at off 3; word at off 1–3. Spans word N = addr[31:2] and N+1 = addr[31:2]+1, which wraps modulo 2^30.
- States: IDLE, RD_LO, RD_HI, WR_HI, DONE.
- IDLE with `req_valid`=1:
  - Latch `req_*`.
  - Drive `ram_address` = `req_addr`, `ram_mem_ctrl` = size code.
  - Drive `ram_data_in` = `req_wdata` unshifted; the RAM does lane placement.
- Native store: `ram_we`=1 in IDLE, then → DONE. `done` arrives 1 cycle after acceptance.
- Native load: `ram_we`=0, then IDLE→RD_LO.
  - In RD_LO, extract from `ram_data_out` into `rdata`, then → DONE. Latency 2 cycles.
- Split load:
  - IDLE: read N.
  - RD_LO: capture `lo`, drive `ram_address` = {N+1,2'b00}, read.
  - RD_HI: form {`ram_data_out`,`lo`}, extract into `rdata`, then → DONE. Latency 3 cycles.
- Split store:
  - IDLE: read N.
  - RD_LO: capture `lo`, read N+1.
  - RD_HI: capture `hi`; write N with `ram_mem_ctrl`=W and merged low word. The merged word is (lo with bytes off..3 replaced by the low bytes of wdata).
  - WR_HI: write N+1 with W, remaining wdata bytes in the low lanes of `hi`.
  - Then → DONE. Latency 4 cycles.
- Extraction: 64-bit {hi,lo} >> 8·off (hi = 0 for native). Then take byte/half/word, sign-extended for LB/LH, zero-extended for LBU/LHU.
- `busy` = (state∉{IDLE,DONE}) | (state==IDLE & `req_valid`).
  - `busy`=0 in DONE, so the core advances at the end of the `done` cycle.
- DONE → IDLE unconditionally. `ram_we`=0 in DONE, RD_LO (loads) and WR_HI-exit.
- After acceptance, `req_*` changes are ignored; the latched copy is used.
- `ram_we`=1 only in: IDLE (native store), RD_HI and WR_HI (split store).

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: split-class requests do no RAM access (`ram_we`=0). They go IDLE→DONE with `fault`=1, `rdata`=0 and `done` 1 cycle after acceptance; native requests are unchanged.
- Undefined: splits are performed as above and `fault` is constant 0.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → store `done` at cycle 1 with `ram_we`=1 once; load `done` at cycle 2 with `rdata`=0xDEADBEEF.
- Mem[0x10]=0x8081_82F3; LB 0x13 → `rdata`=0xFFFFFF80; LBU 0x13 → 0x00000080; LH 0x12 → 0xFFFF8081; LHU 0x11 → 0x00008182.
- Mem[0x10]=0x44332211, mem[0x14]=0x88776655; LW 0x12 → `done` at cycle 3, `rdata`=0x66554433; LH 0x13 → 0x00005544 sign-extended = 0x00005544.
- Same memory, SW 0x11 data 0xAABBCCDD → `ram_we` exactly 2 cycles; mem[0x10]=0xBBCCDD11, mem[0x14]=0x887766AA; `busy` high 4 cycles.
- Split SW asserted, `rst` pulsed in RD_LO → next cycle IDLE, `done`=0, no RAM write; mem unchanged.
- With LSU_MISALIGN_TRAP_EN, LW 0x12 → `done`+`fault` at cycle 1, `rdata`=0, no RAM write; LW 0x10 afterwards completes normally with `fault`=0.
